// File: rtl/axis_burst_chopper.sv
// Splits an AXI4-Stream packet into bursts of at most cfg_burst_len beats and
// queues one length/bytes/eop/tid/tdest descriptor per burst for the write DMA.
module axis_burst_chopper #(
  parameter int unsigned TDATA_BYTES   = 8,
  parameter int unsigned TID_WIDTH     = 4,
  parameter int unsigned TDEST_WIDTH   = 1,
  parameter int unsigned MAX_BURST_LEN = 256,
  parameter int unsigned META_DEPTH    = 4,
  localparam int unsigned LEN_W        = $clog2(MAX_BURST_LEN),
  localparam int unsigned BYTES_W      = $clog2(TDATA_BYTES) + 1,
  localparam int unsigned DATA_W       = 8 * TDATA_BYTES
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [LEN_W:0]         cfg_burst_len,
  input  logic                   target_tvalid,
  output logic                   target_tready,
  input  logic [DATA_W-1:0]      target_tdata,
  input  logic [TDATA_BYTES-1:0] target_tkeep,
  input  logic [TID_WIDTH-1:0]   target_tid,
  input  logic [TDEST_WIDTH-1:0] target_tdest,
  input  logic                   target_tlast,
  output logic                   initiator_tvalid,
  input  logic                   initiator_tready,
  output logic [DATA_W-1:0]      initiator_tdata,
  output logic [TDATA_BYTES-1:0] initiator_tkeep,
  output logic                   initiator_tlast,
  output logic                   meta_tvalid,
  input  logic                   meta_tready,
  output logic [LEN_W-1:0]       meta_tlen,
  output logic [BYTES_W-1:0]     meta_tbytes,
  output logic                   meta_teop,
  output logic [TID_WIDTH-1:0]   meta_tid,
  output logic [TDEST_WIDTH-1:0] meta_tdest,
  output logic [31:0]            stat_bursts
);

  localparam int unsigned PTR_W = $clog2(META_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [LEN_W-1:0]       len;
    logic [BYTES_W-1:0]     bytes;
    logic                   eop;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
  } meta_t;

  // Number of enabled bytes on a beat.
  function automatic logic [BYTES_W-1:0] f_popcount(input logic [TDATA_BYTES-1:0] keep);
    logic [BYTES_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < TDATA_BYTES; i++) begin
      sum = sum + BYTES_W'(keep[i]);
    end
    return sum;
  endfunction

  logic                   r_tvalid;
  logic [DATA_W-1:0]      r_tdata;
  logic [TDATA_BYTES-1:0] r_tkeep;
  logic                   r_tlast;
  logic [LEN_W-1:0]       r_beat_cnt;
  logic [LEN_W:0]         r_lim;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [31:0]            r_stat;
  meta_t                  r_mem [META_DEPTH];

  logic [LEN_W:0]         w_cfg_eff;
  logic [LEN_W:0]         w_lim;
  logic                   w_closing;
  logic                   w_meta_full;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  meta_t                  w_push_desc;
  meta_t                  w_head;

  // 0 or out-of-range configuration selects the hard maximum.
  assign w_cfg_eff = ((cfg_burst_len == '0) || (cfg_burst_len > (LEN_W+1)'(MAX_BURST_LEN)))
                   ? (LEN_W+1)'(MAX_BURST_LEN) : cfg_burst_len;

  // The first beat of a burst uses the live config; later beats use the sampled limit.
  assign w_lim       = (r_beat_cnt == '0) ? w_cfg_eff : r_lim;
  assign w_closing   = target_tlast || ((LEN_W+1)'(r_beat_cnt) == (w_lim - (LEN_W+1)'(1)));
  assign w_meta_full = (r_count == CNT_W'(META_DEPTH));

  // Only a burst-closing beat needs a free descriptor slot.
  assign w_ready  = (!r_tvalid || initiator_tready) && !(w_meta_full && w_closing);
  assign w_accept = target_tvalid && w_ready;
  assign w_push   = w_accept && w_closing;
  assign w_pop    = (r_count != '0) && meta_tready;

  assign w_push_desc.len   = r_beat_cnt;
  assign w_push_desc.bytes = f_popcount(target_tkeep);
  assign w_push_desc.eop   = target_tlast;
  assign w_push_desc.tid   = target_tid;
  assign w_push_desc.tdest = target_tdest;

  assign w_head = r_mem[r_rd_ptr];

  // Control state, counters and FIFO pointers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid   <= 1'b0;
      r_beat_cnt <= '0;
      r_lim      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_stat     <= '0;
    end else begin
      if (w_accept) begin
        r_tvalid <= 1'b1;
      end else if (initiator_tready) begin
        r_tvalid <= 1'b0;
      end

      if (w_accept) begin
        if (r_beat_cnt == '0) begin
          r_lim <= w_cfg_eff;
        end
        if (w_closing) begin
          r_beat_cnt <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + LEN_W'(1);
        end
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_stat   <= r_stat + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload registers carry no reset; they are qualified by the valids.
  always_ff @(posedge aclk) begin
    if (w_accept) begin
      r_tdata <= target_tdata;
      r_tkeep <= target_tkeep;
      r_tlast <= w_closing;
    end
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_desc;
    end
  end

  assign target_tready    = w_ready;
  assign initiator_tvalid = r_tvalid;
  assign initiator_tdata  = r_tdata;
  assign initiator_tkeep  = r_tkeep;
  assign initiator_tlast  = r_tlast;
  assign meta_tvalid      = (r_count != '0);
  assign meta_tlen        = w_head.len;
  assign meta_tbytes      = w_head.bytes;
  assign meta_teop        = w_head.eop;
  assign meta_tid         = w_head.tid;
  assign meta_tdest       = w_head.tdest;
  assign stat_bursts      = r_stat;

endmodule

// File: tb/tb_axis_burst_chopper.sv
// Scoreboard bench for axis_burst_chopper: a reference burst-splitting model
// feeds expected beat/descriptor queues that output monitors pop and compare.
module tb_axis_burst_chopper;

  logic        aclk;
  logic        aresetn;
  logic [8:0]  cfg_burst_len;
  logic        target_tvalid;
  logic        target_tready;
  logic [63:0] target_tdata;
  logic [7:0]  target_tkeep;
  logic [3:0]  target_tid;
  logic [0:0]  target_tdest;
  logic        target_tlast;
  logic        initiator_tvalid;
  logic        initiator_tready;
  logic [63:0] initiator_tdata;
  logic [7:0]  initiator_tkeep;
  logic        initiator_tlast;
  logic        meta_tvalid;
  logic        meta_tready;
  logic [7:0]  meta_tlen;
  logic [3:0]  meta_tbytes;
  logic        meta_teop;
  logic [3:0]  meta_tid;
  logic [0:0]  meta_tdest;
  logic [31:0] stat_bursts;

  axis_burst_chopper dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cfg_burst_len    (cfg_burst_len),
    .target_tvalid    (target_tvalid),
    .target_tready    (target_tready),
    .target_tdata     (target_tdata),
    .target_tkeep     (target_tkeep),
    .target_tid       (target_tid),
    .target_tdest     (target_tdest),
    .target_tlast     (target_tlast),
    .initiator_tvalid (initiator_tvalid),
    .initiator_tready (initiator_tready),
    .initiator_tdata  (initiator_tdata),
    .initiator_tkeep  (initiator_tkeep),
    .initiator_tlast  (initiator_tlast),
    .meta_tvalid      (meta_tvalid),
    .meta_tready      (meta_tready),
    .meta_tlen        (meta_tlen),
    .meta_tbytes      (meta_tbytes),
    .meta_teop        (meta_teop),
    .meta_tid         (meta_tid),
    .meta_tdest       (meta_tdest),
    .stat_bursts      (stat_bursts)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [7:0] len;
    logic [3:0] bytes;
    logic       eop;
    logic [3:0] tid;
    logic [0:0] tdest;
  } desc_t;

  int    checks = 0;
  int    failures = 0;
  beat_t exp_data[$];
  desc_t exp_meta[$];
  int    obs_len[$];
  int    obs_bytes[$];
  int    obs_eop[$];
  int    obs_last_idx[$];
  int    out_beats;
  int    in_beats;
  longint sum_len;
  int    m_cnt;
  int    m_lim;
  int    exp_bursts;
  bit    rnd_mode;
  bit    itr_set;
  bit    mtr_set;

  function automatic int eff_len(input int c);
    return (c == 0 || c > 256) ? 256 : c;
  endfunction

  // Reference model: decides burst boundaries for an accepted input beat.
  function automatic void model_accept(input logic [63:0] d, input logic [7:0] k, input logic l,
                                       input logic [3:0] id, input logic [0:0] dst);
    bit    cl;
    beat_t b;
    desc_t m;
    if (m_cnt == 0) m_lim = eff_len(int'(cfg_burst_len));
    cl = l || (m_cnt == m_lim - 1);
    b = {d, k, cl};
    exp_data.push_back(b);
    in_beats++;
    if (cl) begin
      m = {8'(m_cnt), 4'($countones(k)), l, id, dst};
      exp_meta.push_back(m);
      exp_bursts++;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endfunction

  // Ready generation plus output monitors; readies settle before handshakes are evaluated.
  always @(negedge aclk) begin
    beat_t e;
    beat_t g;
    desc_t em;
    desc_t gm;
    if (rnd_mode) begin
      initiator_tready = ($urandom_range(0, 99) >= 30);
      meta_tready      = ($urandom_range(0, 99) >= 30);
    end else begin
      initiator_tready = itr_set;
      meta_tready      = mtr_set;
    end
    if (aresetn === 1'b1 && initiator_tvalid === 1'b1 && initiator_tready) begin
      out_beats++;
      if (initiator_tlast) obs_last_idx.push_back(out_beats);
      checks++;
      g = {initiator_tdata, initiator_tkeep, initiator_tlast};
      if (exp_data.size() == 0) begin
        failures++;
        $display("FAIL data_unexpected got=%h expected=none", g);
      end else begin
        e = exp_data.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL data_beat got=%h expected=%h", g, e);
        end
      end
    end
    if (aresetn === 1'b1 && meta_tvalid === 1'b1 && meta_tready) begin
      gm = {meta_tlen, meta_tbytes, meta_teop, meta_tid, meta_tdest};
      obs_len.push_back(int'(meta_tlen));
      obs_bytes.push_back(int'(meta_tbytes));
      obs_eop.push_back(int'(meta_teop));
      sum_len += longint'(meta_tlen) + 1;
      checks++;
      if (exp_meta.size() == 0) begin
        failures++;
        $display("FAIL meta_unexpected got=%h expected=none", gm);
      end else begin
        em = exp_meta.pop_front();
        if (gm !== em) begin
          failures++;
          $display("FAIL meta_desc got=%h expected=%h", gm, em);
        end
      end
    end
  end

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic [3:0] id, input logic [0:0] dst);
    bit ok;
    ok = 1'b0;
    target_tdata  = d;
    target_tkeep  = k;
    target_tlast  = l;
    target_tid    = id;
    target_tdest  = dst;
    target_tvalid = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      @(negedge aclk);
      #1;
      if (target_tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout target_tready=%b expected=1", target_tready);
    end else begin
      model_accept(d, k, l, id, dst);
    end
    @(posedge aclk);
    #1;
    target_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] last_keep, input logic [3:0] id,
                          input logic [0:0] dst);
    for (int i = 0; i < n; i++) begin
      drive_beat({$urandom, $urandom}, (i == n - 1) ? last_keep : 8'hFF, (i == n - 1), id, dst);
    end
  endtask

  task automatic drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge aclk);
      #1;
      if (exp_data.size() == 0 && exp_meta.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || initiator_tvalid !== 1'b0 || meta_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain pending_data=%0d pending_meta=%0d ivalid=%b mvalid=%b expected=0,0,0,0",
               name, exp_data.size(), exp_meta.size(), initiator_tvalid, meta_tvalid);
    end
  endtask

  task automatic clear_obs();
    obs_len.delete();
    obs_bytes.delete();
    obs_eop.delete();
    obs_last_idx.delete();
    out_beats = 0;
    in_beats  = 0;
    sum_len   = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    checks++;
    if (initiator_tvalid !== 1'b0 || meta_tvalid !== 1'b0 || stat_bursts !== 32'd0) begin
      failures++;
      $display("FAIL reset_state ivalid=%b mvalid=%b stat=%0d expected=0,0,0",
               initiator_tvalid, meta_tvalid, stat_bursts);
    end
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    checks++;
    if (target_tready !== 1'b1 || initiator_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release tready=%b ivalid=%b expected=1,0", target_tready, initiator_tvalid);
    end
  endtask

  task automatic test_t1_basic();
    int el[3] = '{3, 3, 1};
    int eb[3] = '{8, 8, 4};
    int ee[3] = '{0, 0, 1};
    int et[3] = '{4, 8, 10};
    clear_obs();
    cfg_burst_len = 9'd4;
    send_pkt(10, 8'h0F, 4'h3, 1'b1);
    drain("t1", 200);
    checks++;
    if (obs_len.size() != 3 || obs_last_idx.size() != 3) begin
      failures++;
      $display("FAIL t1_count bursts=%0d tlasts=%0d expected=3,3", obs_len.size(), obs_last_idx.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_len[i] != el[i] || obs_bytes[i] != eb[i] || obs_eop[i] != ee[i] || obs_last_idx[i] != et[i]) begin
          failures++;
          $display("FAIL t1_burst%0d len=%0d bytes=%0d eop=%0d tlast_at=%0d expected=%0d,%0d,%0d,%0d",
                   i, obs_len[i], obs_bytes[i], obs_eop[i], obs_last_idx[i], el[i], eb[i], ee[i], et[i]);
        end
      end
    end
  endtask

  task automatic test_t2_max_len();
    clear_obs();
    cfg_burst_len = 9'd0;
    send_pkt(300, 8'hFF, 4'h5, 1'b0);
    drain("t2", 500);
    checks++;
    if (obs_len.size() != 2 || obs_len[0] != 255 || obs_eop[0] != 0 || obs_len[1] != 43 || obs_eop[1] != 1) begin
      failures++;
      $display("FAIL t2_lens bursts=%0d first_len=%0d expected=2,255 then 43 with eop",
               obs_len.size(), (obs_len.size() > 0) ? obs_len[0] : -1);
    end
    checks++;
    if (stat_bursts !== 32'(exp_bursts)) begin
      failures++;
      $display("FAIL t2_stat stat_bursts=%0d expected=%0d", stat_bursts, exp_bursts);
    end
  endtask

  task automatic test_t3_meta_backpressure();
    clear_obs();
    itr_set = 1'b1;
    mtr_set = 1'b0;
    cfg_burst_len = 9'd1;
    for (int i = 0; i < 4; i++) drive_beat(64'(i) + 64'h1000, 8'hFF, 1'b0, 4'(i), 1'(i));
    target_tdata  = 64'h1004;
    target_tkeep  = 8'hFF;
    target_tlast  = 1'b0;
    target_tid    = 4'd4;
    target_tdest  = 1'b0;
    target_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1;
      checks++;
      if (target_tready !== 1'b0 || meta_tvalid !== 1'b1) begin
        failures++;
        $display("FAIL t3_stall cycle=%0d tready=%b mvalid=%b expected=0,1", i, target_tready, meta_tvalid);
      end
    end
    mtr_set = 1'b1;
    drive_beat(64'h1004, 8'hFF, 1'b0, 4'd4, 1'b0);
    drive_beat(64'h1005, 8'h03, 1'b1, 4'd5, 1'b1);
    drain("t3", 200);
    checks++;
    if (obs_len.size() != 6 || obs_eop[5] != 1 || obs_eop[4] != 0 || obs_bytes[5] != 2) begin
      failures++;
      $display("FAIL t3_bursts count=%0d expected=6 with eop only on last", obs_len.size());
    end
  endtask

  task automatic test_t4_cfg_change();
    clear_obs();
    cfg_burst_len = 9'd8;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) cfg_burst_len = 9'd2;
      drive_beat({$urandom, $urandom}, 8'hFF, (i == 12), 4'h7, 1'b1);
    end
    drain("t4", 200);
    checks++;
    if (obs_last_idx.size() != 3 || obs_last_idx[0] != 8 || obs_last_idx[1] != 10 || obs_last_idx[2] != 12) begin
      failures++;
      $display("FAIL t4_tlast_pos count=%0d first=%0d expected=3 at 8,10,12",
               obs_last_idx.size(), (obs_last_idx.size() > 0) ? obs_last_idx[0] : -1);
    end
  endtask

  task automatic test_t5_random();
    clear_obs();
    rnd_mode = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) cfg_burst_len = 9'($urandom_range(257, 511));
        else cfg_burst_len = 9'($urandom_range(0, 6));
        drive_beat({$urandom, $urandom}, (i == n - 1) ? 8'(8'hFF >> $urandom_range(0, 7)) : 8'hFF,
                   (i == n - 1), 4'($urandom), 1'($urandom));
      end
    end
    drain("t5", 20000);
    rnd_mode = 1'b0;
    checks++;
    if (sum_len != longint'(out_beats) || out_beats != in_beats) begin
      failures++;
      $display("FAIL t5_len_sum sum_len=%0d out_beats=%0d expected=%0d", sum_len, out_beats, in_beats);
    end
  endtask

  task automatic test_t6_reset_mid_burst();
    clear_obs();
    itr_set = 1'b1;
    mtr_set = 1'b0;
    cfg_burst_len = 9'd1;
    for (int i = 0; i < 3; i++) drive_beat(64'(i), 8'hFF, 1'b0, 4'(i), 1'b0);
    cfg_burst_len = 9'd4;
    drive_beat(64'hA0, 8'hFF, 1'b0, 4'h1, 1'b0);
    drive_beat(64'hA1, 8'hFF, 1'b0, 4'h1, 1'b0);
    checks++;
    if (meta_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL t6_queued mvalid=%b expected=1", meta_tvalid);
    end
    aresetn = 1'b0;
    exp_data.delete();
    exp_meta.delete();
    m_cnt = 0;
    exp_bursts = 0;
    @(posedge aclk);
    #1;
    checks++;
    if (initiator_tvalid !== 1'b0 || meta_tvalid !== 1'b0 || stat_bursts !== 32'd0) begin
      failures++;
      $display("FAIL t6_reset ivalid=%b mvalid=%b stat=%0d expected=0,0,0",
               initiator_tvalid, meta_tvalid, stat_bursts);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    mtr_set = 1'b1;
    cfg_burst_len = 9'd2;
    @(posedge aclk);
    #1;
    clear_obs();
    send_pkt(3, 8'h07, 4'h9, 1'b1);
    drain("t6", 200);
    checks++;
    if (obs_len.size() != 2 || obs_len[0] != 1 || obs_len[1] != 0 || stat_bursts !== 32'd2) begin
      failures++;
      $display("FAIL t6_after_reset bursts=%0d first_len=%0d stat=%0d expected=2,1,2",
               obs_len.size(), (obs_len.size() > 0) ? obs_len[0] : -1, stat_bursts);
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    cfg_burst_len = 9'd4;
    target_tvalid = 1'b0;
    target_tdata  = '0;
    target_tkeep  = '0;
    target_tid    = '0;
    target_tdest  = '0;
    target_tlast  = 1'b0;
    rnd_mode      = 1'b0;
    itr_set       = 1'b1;
    mtr_set       = 1'b1;
    m_cnt         = 0;
    m_lim         = 256;
    exp_bursts    = 0;
    clear_obs();
    test_reset();
    test_t1_basic();
    test_t2_max_len();
    test_t3_meta_backpressure();
    test_t4_cfg_change();
    test_t5_random();
    test_t6_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
